// File: rtl/dmac_mc_locked.sv
// N-channel DMA transfer sequencer with a key-locked control FSM (wrong key loops ARB<->decoy).
// Define DMAC_FIXED_PRIO_EN for lowest-index-first arbitration instead of round-robin.
module dmac_mc_locked #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8,
    parameter int KEY_W = 4,
    parameter logic [KEY_W-1:0] KEY_VAL = 'hA
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCH-1:0]        req,
    input  logic [NCH*CNT_W-1:0]  len,
    input  logic                  bus_rdy,
    input  logic                  abort,
    input  logic [KEY_W-1:0]      keyinput,
    output logic [NCH-1:0]        gnt,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] ch_id,
    output logic                  rd_en,
    output logic                  wr_en,
    output logic                  addr_inc,
    output logic [NCH-1:0]        done,
    output logic                  err,
    output logic                  busy
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARB     = 3'd1;
    localparam logic [2:0] S_RD      = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_WR      = 3'd4;
    localparam logic [2:0] S_WR_WAIT = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;
    localparam logic [2:0] S_RD_D    = 3'd7;

    logic [2:0]       state;
    logic [CH_W-1:0]  ch;
    logic [CH_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] cnt;

    logic [CNT_W-1:0] lens [NCH];
    logic             found;
    logic [CH_W-1:0]  pick;
    logic [CNT_W-1:0] pick_len;
    logic             key_ok;
    logic             in_xfer;
    logic             abortable;

    for (genvar g = 0; g < NCH; g++) begin : g_len
        assign lens[g] = len[g*CNT_W +: CNT_W];
    end

    assign key_ok    = (keyinput == KEY_VAL);
    assign abortable = (state != S_IDLE) && (state != S_DONE);

    always_comb begin
        found    = 1'b0;
        pick     = '0;
        pick_len = '0;
`ifdef DMAC_FIXED_PRIO_EN
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!found && req[CH_W'(i)]) begin
                found    = 1'b1;
                pick     = CH_W'(i);
                pick_len = lens[CH_W'(i)];
            end
        end
`else
        // Search starts one past the last served channel and wraps.
        for (int unsigned i = 1; i <= NCH; i++) begin
            logic [CH_W-1:0] sel;
            sel = CH_W'((32'(rr_ptr) + i) % NCH);
            if (!found && req[sel]) begin
                found    = 1'b1;
                pick     = sel;
                pick_len = lens[sel];
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            ch     <= '0;
            rr_ptr <= CH_W'(NCH - 1);
        end else if (abort && abortable) begin
            state  <= S_IDLE;
            rr_ptr <= ch;
        end else begin
            case (state)
                S_IDLE:    if (|req) state <= S_ARB;
                S_ARB: begin
                    if (!found) begin
                        state <= S_IDLE;
                    end else begin
                        ch  <= pick;
                        cnt <= pick_len;
                        if (!key_ok)
                            state <= S_RD_D;
                        else if (pick_len == '0)
                            state <= S_DONE;
                        else
                            state <= S_RD;
                    end
                end
                S_RD:      state <= S_RD_WAIT;
                S_RD_WAIT: if (bus_rdy) state <= S_WR;
                S_WR:      state <= S_WR_WAIT;
                S_WR_WAIT: begin
                    if (bus_rdy) begin
                        cnt   <= cnt - CNT_W'(1);
                        state <= (cnt == CNT_W'(1)) ? S_DONE : S_RD;
                    end
                end
                S_DONE: begin
                    rr_ptr <= ch;
                    state  <= (|req) ? S_ARB : S_IDLE;
                end
                S_RD_D:    state <= key_ok ? S_RD : S_ARB;
                default:   state <= S_IDLE;
            endcase
        end
    end

    // Grant is visible from ARB exit until DONE, including the decoy state.
    assign in_xfer  = (state != S_IDLE) && (state != S_ARB);
    assign gnt      = in_xfer ? (NCH'(1) << ch) : '0;
    assign ch_id    = in_xfer ? ch : '0;
    assign done     = (state == S_DONE) ? (NCH'(1) << ch) : '0;
    assign rd_en    = (state == S_RD) || (state == S_RD_D);
    assign wr_en    = (state == S_WR);
    assign addr_inc = (state == S_WR_WAIT) && bus_rdy && !abort;
    assign err      = abort && abortable;
    assign busy     = (state != S_IDLE);
endmodule

// File: tb/tb_dmac_mc_locked.sv
// Directed bench for dmac_mc_locked: done pulses are scoreboarded against a queue of expected grants.
module tb_dmac_mc_locked;
    localparam int NCH   = 4;
    localparam int CNT_W = 8;
    localparam int KEY_W = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NCH-1:0]       req;
    logic [NCH*CNT_W-1:0] len;
    logic                 bus_rdy;
    logic                 abort;
    logic [KEY_W-1:0]     keyinput;
    logic [NCH-1:0]       gnt;
    logic [1:0]           ch_id;
    logic                 rd_en;
    logic                 wr_en;
    logic                 addr_inc;
    logic [NCH-1:0]       done;
    logic                 err;
    logic                 busy;

    always #5 clk = ~clk;

    dmac_mc_locked #(
        .NCH(NCH),
        .CNT_W(CNT_W),
        .KEY_W(KEY_W),
        .KEY_VAL(4'hA)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .len(len), .bus_rdy(bus_rdy),
        .abort(abort), .keyinput(keyinput), .gnt(gnt), .ch_id(ch_id),
        .rd_en(rd_en), .wr_en(wr_en), .addr_inc(addr_inc), .done(done),
        .err(err), .busy(busy)
    );

    int          n_pass = 0;
    int          n_fail = 0;
    int          n_total = 0;
    int unsigned cyc = 0, rd_n = 0, wr_n = 0, inc_n = 0, err_n = 0, done_n = 0;
    int unsigned gnt_cyc = 0, done_cyc = 0;
    logic [NCH-1:0] prev_gnt = '0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Output monitor: samples on the falling edge, pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (rd_en)    rd_n++;
            if (wr_en)    wr_n++;
            if (addr_inc) inc_n++;
            if (err)      err_n++;
            if (gnt != '0 && prev_gnt == '0) gnt_cyc = cyc;
            if (done != '0) begin
                done_n++;
                done_cyc = cyc;
                if (exp_q.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
                else                   chk("done_ch", 32'(done), exp_q.pop_front());
            end
            prev_gnt = gnt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_gnt(input string tag);
        for (int i = 0; i < 20 && gnt == '0; i++) tick();
        chk(tag, 32'(gnt != '0), 32'd1);
    endtask

    task automatic wait_dones(input int unsigned target, input int budget, input string tag);
        for (int i = 0; i < budget && done_n < target; i++) tick();
        chk(tag, 32'(done_n >= target), 32'd1);
    endtask

    int unsigned b_rd, b_wr, b_inc, b_err, b_done;
    int          wcnt;

    initial begin
        rst = 1'b1; req = 4'b1111; len = '1; bus_rdy = 1'b1; abort = 1'b1; keyinput = 4'hA;
        tick(); tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_ch_id", 32'(ch_id), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_addr_inc", 32'(addr_inc), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        req = '0; len = '0; abort = 1'b0;
        rst = 1'b0;
        tick();

        // 1: single channel, 3 beats
        len = {8'd0, 8'd0, 8'd0, 8'd3};
        b_rd = rd_n; b_wr = wr_n; b_inc = inc_n; b_done = done_n;
        exp_q.push_back(32'h1);
        req = 4'b0001;
        wait_gnt("t1_gnt_wait");
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_ch_id", 32'(ch_id), 32'd0);
        req = '0;
        wait_dones(b_done + 1, 40, "t1_done_wait");
        repeat (3) tick();
        chk("t1_rd_cnt", rd_n - b_rd, 32'd3);
        chk("t1_wr_cnt", wr_n - b_wr, 32'd3);
        chk("t1_inc_cnt", inc_n - b_inc, 32'd3);
        chk("t1_latency", done_cyc - gnt_cyc, 32'd12);
        chk("t1_idle", 32'(busy), 32'd0);

        // 2: all channels requesting, len=1 each
        do_reset();
        len = {8'd1, 8'd1, 8'd1, 8'd1};
        b_done = done_n;
        for (int k = 0; k < 6; k++) begin
`ifdef DMAC_FIXED_PRIO_EN
            exp_q.push_back(32'h1);
`else
            exp_q.push_back(32'h1 << (k % 4));
`endif
        end
        req = 4'b1111;
        wait_dones(b_done + 6, 200, "t2_done_wait");
        req = '0;
        repeat (8) tick();
        chk("t2_idle", 32'(busy), 32'd0);
        chk("t2_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        // 3: wrong key keeps the FSM in the decoy loop
        len = {8'd0, 8'd0, 8'd4, 8'd0};
        keyinput = 4'h5;
        b_rd = rd_n; b_wr = wr_n; b_done = done_n;
        req = 4'b0010;
        repeat (100) tick();
        chk("t3_no_wr", wr_n - b_wr, 32'd0);
        chk("t3_no_done", done_n - b_done, 32'd0);
        chk("t3_decoy_rd", 32'(rd_n > b_rd), 32'd1);
        chk("t3_busy", 32'(busy), 32'd1);
        b_inc = inc_n;
        exp_q.push_back(32'h2);
        keyinput = 4'hA;
        for (int i = 0; i < 20 && !wr_en; i++) tick();
        chk("t3_unlocked_wr", 32'(wr_en), 32'd1);
        req = '0;
        wait_dones(b_done + 1, 60, "t3_done_wait");
        repeat (3) tick();
        chk("t3_inc_cnt", inc_n - b_inc, 32'd4);

        // 4: zero-length transfer skips the bus entirely
        len = '0;
        b_rd = rd_n; b_wr = wr_n; b_done = done_n;
        exp_q.push_back(32'h4);
        req = 4'b0100;
        wait_gnt("t4_gnt_wait");
        chk("t4_gnt", 32'(gnt), 32'h4);
        req = '0;
        wait_dones(b_done + 1, 10, "t4_done_wait");
        repeat (3) tick();
        chk("t4_no_rd", rd_n - b_rd, 32'd0);
        chk("t4_no_wr", wr_n - b_wr, 32'd0);

        // 5: abort during WR_WAIT of beat 2 of 5 on ch1
        do_reset();
        len = {8'd0, 8'd0, 8'd5, 8'd0};
        bus_rdy = 1'b1;
        b_inc = inc_n; b_err = err_n; b_done = done_n;
        req = 4'b0010;
        wcnt = 0;
        for (int i = 0; i < 40 && wcnt < 2; i++) begin
            tick();
            if (wr_en) wcnt++;
        end
        chk("t5_second_wr", 32'(wcnt), 32'd2);
        bus_rdy = 1'b0;
        req = '0;
        tick();
        chk("t5_wr_wait_stall", 32'(addr_inc), 32'd0);
        abort = 1'b1;
        bus_rdy = 1'b1;
        #1;
        chk("t5_err", 32'(err), 32'd1);
        chk("t5_abort_prio", 32'(addr_inc), 32'd0);
        tick();
        abort = 1'b0;
        chk("t5_idle", 32'(busy), 32'd0);
        chk("t5_gnt_clear", 32'(gnt), 32'd0);
        chk("t5_inc_cnt", inc_n - b_inc, 32'd1);
        chk("t5_err_cnt", err_n - b_err, 32'd1);
        chk("t5_no_done", done_n - b_done, 32'd0);
        len = {8'd1, 8'd1, 8'd1, 8'd1};
        exp_q.push_back(32'h4);
        req = 4'b1111;
        wait_dones(b_done + 1, 40, "t5_next_done_wait");
        req = '0;
        repeat (6) tick();

        // 6: reset in RD_WAIT
        len = {8'd0, 8'd0, 8'd0, 8'd2};
        bus_rdy = 1'b0;
        req = 4'b0001;
        for (int i = 0; i < 20 && !rd_en; i++) tick();
        chk("t6_rd", 32'(rd_en), 32'd1);
        tick();
        chk("t6_rd_wait_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_gnt", 32'(gnt), 32'd0);
        chk("t6_rst_outs", 32'({ch_id, rd_en, wr_en, addr_inc, done, err}), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        len = {8'd0, 8'd0, 8'd0, 8'd1};
        bus_rdy = 1'b1;
        tick();
        b_done = done_n;
        exp_q.push_back(32'h1);
        rst = 1'b0;
        wait_gnt("t6_gnt_wait");
        chk("t6_first_gnt", 32'(gnt), 32'h1);
        req = '0;
        wait_dones(b_done + 1, 30, "t6_done_wait");
        repeat (4) tick();
        chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
